// File: rtl/wrapper_io_pkg.sv
// Shared types and sizing helpers for the wrapper_io_serdes slice.
package wrapper_io_pkg;

  typedef enum logic [1:0] {FILL, APPLY, WAIT, DRAIN} state_t;

  localparam int VEC_COUNT_W = 16;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width of a counter that indexes 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrapper_io_shift_out.sv
// Output serializer: loads the captured outp vector and emits it LS chunk first.
// WRAP_IO_CHECKSUM_EN appends an XOR-of-chunks word after the data chunks.
module wrapper_io_shift_out
  import wrapper_io_pkg::*;
#(
  parameter int OUT_W   = 32,
  parameter int CHUNK_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [OUT_W-1:0]   load_data,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [CHUNK_W-1:0] m_data,
  output logic               done
);

  localparam int NOUT = ceil_div(OUT_W, CHUNK_W);
`ifdef WRAP_IO_CHECKSUM_EN
  localparam int NCH  = NOUT + 1;
`else
  localparam int NCH  = NOUT;
`endif
  localparam int SW   = NOUT * CHUNK_W;
  localparam int IW   = cnt_w(NCH);

  logic [SW-1:0]      ext;
  logic [SW-1:0]      sreg;
  logic [IW-1:0]      idx;
  logic [CHUNK_W-1:0] nxt_chunk;
  logic               adv;
  logic               last;

  // Pad bits above OUT_W read as zero in the final data chunk.
  always_comb begin
    ext            = '0;
    ext[OUT_W-1:0] = load_data;
  end

  assign adv  = m_valid && m_ready;
  assign last = (idx == IW'(NCH - 1));
  assign done = adv && last;

`ifdef WRAP_IO_CHECKSUM_EN
  logic [CHUNK_W-1:0] csum;

  function automatic logic [CHUNK_W-1:0] xor_chunks(input logic [SW-1:0] v);
    logic [CHUNK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NOUT; i++) acc ^= v[i*CHUNK_W +: CHUNK_W];
    return acc;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    csum <= '0;
    else if (load) csum <= xor_chunks(ext);
  end

  assign nxt_chunk = (idx == IW'(NOUT - 1)) ? csum : sreg[CHUNK_W-1:0];
`else
  assign nxt_chunk = sreg[CHUNK_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      sreg    <= '0;
      idx     <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= ext[CHUNK_W-1:0];
      sreg    <= ext >> CHUNK_W;
      idx     <= '0;
    end else if (adv) begin
      if (last) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else begin
        idx    <= idx + 1'b1;
        m_data <= nxt_chunk;
        sreg   <= sreg >> CHUNK_W;
      end
    end
  end

endmodule

// File: rtl/wrapper_io_serdes.sv
// Pin-limited I/O front end: deserialize inp, wait LAT cycles, serialize outp.
// Optional WRAP_IO_CHECKSUM_EN adds a checksum chunk to each output vector.
module wrapper_io_serdes
  import wrapper_io_pkg::*;
#(
  parameter int IN_W    = 256,
  parameter int OUT_W   = 32,
  parameter int CHUNK_W = 16,
  parameter int LAT     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [CHUNK_W-1:0]     s_data,
  output logic [IN_W-1:0]        inp_bus,
  output logic                   inp_load,
  input  logic [OUT_W-1:0]       outp_bus,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CHUNK_W-1:0]     m_data,
  output logic [VEC_COUNT_W-1:0] vec_count
);

  localparam int NIN = ceil_div(IN_W, CHUNK_W);
  localparam int SHW = NIN * CHUNK_W;
  localparam int CIW = cnt_w(NIN);
  localparam int LW  = cnt_w(LAT);

  state_t         state;
  state_t         nxt;
  logic [SHW-1:0] shadow;
  logic [CIW-1:0] cnt;
  logic [LW-1:0]  lat_cnt;
  logic           accept;
  logic           apply;
  logic           capture;
  logic           last_in;
  logic           lat_done;
  logic           done;

  assign last_in  = (cnt == CIW'(NIN - 1));
  assign lat_done = (lat_cnt == LW'(LAT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      FILL:    if (accept && last_in) nxt = APPLY;
      APPLY:   nxt = WAIT;
      WAIT:    if (lat_done) nxt = DRAIN;
      DRAIN:   if (done) nxt = FILL;
      default: nxt = FILL;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    apply   = 1'b0;
    capture = 1'b0;
    case (state)
      FILL:    accept  = s_valid && s_ready;
      APPLY:   apply   = 1'b1;
      WAIT:    capture = lat_done;
      default: ;
    endcase
  end

  // s_ready tracks the upcoming state so it rises one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready  <= 1'b0;
      inp_load <= 1'b0;
    end else begin
      s_ready  <= (nxt == FILL);
      inp_load <= apply;
    end
  end

  // Input assembly: slot cnt of the shadow vector, LS chunk first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (accept) begin
      shadow[cnt*CHUNK_W +: CHUNK_W] <= s_data;
      cnt <= last_in ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     inp_bus <= '0;
    else if (apply) inp_bus <= shadow[IN_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         lat_cnt <= '0;
    else if (state == WAIT && !lat_done) lat_cnt <= lat_cnt + 1'b1;
    else                                lat_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    vec_count <= '0;
    else if (done) vec_count <= vec_count + 1'b1;
  end

  wrapper_io_shift_out #(
    .OUT_W   (OUT_W),
    .CHUNK_W (CHUNK_W)
  ) u_shift_out (
    .clk       (clk),
    .reset     (reset),
    .load      (capture),
    .load_data (outp_bus),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .done      (done)
  );

endmodule

// File: tb/tb_wrapper_io_serdes.sv
// Bench for wrapper_io_serdes with a summing proxy as the wrapped module.
`timescale 1ns/1ps
module tb_wrapper_io_serdes;

  localparam int IN_W    = 64;
  localparam int OUT_W   = 32;
  localparam int CHUNK_W = 16;
  localparam int LAT     = 2;
  localparam int NIN     = 4;
`ifdef WRAP_IO_CHECKSUM_EN
  localparam int NCH     = 3;
`else
  localparam int NCH     = 2;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [CHUNK_W-1:0] s_data = '0;
  logic [IN_W-1:0]    inp_bus;
  logic               inp_load;
  logic [OUT_W-1:0]   outp_bus;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [CHUNK_W-1:0] m_data;
  logic [15:0]        vec_count;

  int          checks = 0;
  int          failures = 0;
  int          load_cnt = 0;
  logic [15:0] exp_vc = '0;

  always #5 clk = ~clk;

  wrapper_io_serdes #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CHUNK_W(CHUNK_W), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .inp_bus(inp_bus), .inp_load(inp_load), .outp_bus(outp_bus),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .vec_count(vec_count)
  );

  // Wrapped-module proxy: registered sum, settled before the capture edge.
  logic [31:0] outp_r;
  always @(posedge clk) outp_r <= inp_bus[31:0] + inp_bus[63:32];
  assign outp_bus = outp_r;

  always @(negedge clk) if (inp_load) load_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_inp_load"}, inp_load, 0);
    chk({tag, "_inp_bus"}, inp_bus, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    chk("s_ready_before_edge", s_ready, 0);
    step();
    chk("s_ready_after_edge", s_ready, 1);
  endtask

  // mode 0: back-to-back chunks, 1: alternating bubbles, 2: random bubbles and stalls
  task automatic run_vector(input logic [63:0] v, input int mode, input int stall);
    int          acc;
    int          cyc;
    int          loads0;
    int          waitc;
    int          st;
    logic        rdy;
    logic [31:0] sum;
    logic [15:0] exp_ch [3];
    acc = 0;
    cyc = 0;
    sum = v[31:0] + v[63:32];
    exp_ch[0] = sum[15:0];
    exp_ch[1] = sum[31:16];
    exp_ch[2] = sum[15:0] ^ sum[31:16];
    loads0 = load_cnt;
    while (acc < NIN && cyc < 200) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data  = s_valid ? v[acc*16 +: 16] : 16'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      rdy = s_ready;
      step();
      cyc++;
      if (s_valid && rdy) acc++;
      if (acc < NIN) chk("no_early_load", inp_load, 0);
    end
    chk("accepted_chunks", acc, NIN);
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    chk("s_ready_drop", s_ready, 0);
    chk("load_count_pre", load_cnt, loads0);
    step();
    chk("inp_load_pulse", inp_load, 1);
    chk("inp_bus", inp_bus, v);
    waitc = 1;
    step();
    chk("inp_load_drop", inp_load, 0);
    chk("load_count_once", load_cnt, loads0 + 1);
    while (!m_valid && waitc < 20) begin
      chk("s_ready_wait", s_ready, 0);
      step();
      waitc++;
    end
    chk("capture_latency", waitc, LAT);
    for (int k = 0; k < NCH; k++) begin
      st = (mode == 2) ? $urandom_range(0, 2) : ((k == 0) ? stall : 0);
      m_ready = 1'b0;
      for (int j = 0; j < st; j++) begin
        step();
        chk("hold_m_valid", m_valid, 1);
        chk("hold_m_data", m_data, exp_ch[k]);
        chk("hold_s_ready", s_ready, 0);
      end
      chk("m_valid", m_valid, 1);
      chk($sformatf("m_data_%0d", k), m_data, exp_ch[k]);
      chk("vec_count_pre", vec_count, exp_vc);
      m_ready = 1'b1;
      if (k == NCH - 1) s_valid = 1'b0;
      step();
    end
    exp_vc = exp_vc + 16'd1;
    chk("vec_count_post", vec_count, exp_vc);
    chk("m_valid_drop", m_valid, 0);
    chk("s_ready_back", s_ready, 1);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    int          acc;
    logic        rdy;

    #1;
    chk_all_zero("reset");
    repeat (3) step();
    chk_all_zero("reset_held");
    release_reset();

    run_vector(64'h0004_0003_0002_0001, 0, 0);
    run_vector(64'h0004_0003_0002_0001, 0, 5);
    run_vector({$urandom, $urandom}, 1, 0);

    // Partial vector then reset; the fresh vector must carry no stale chunks.
    v = {$urandom, $urandom};
    acc = 0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      s_valid = 1'b1;
      s_data  = v[acc*16 +: 16];
      rdy = s_ready;
      step();
      if (rdy) acc++;
    end
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_fill_reset");
    exp_vc = '0;
    step();
    release_reset();
    run_vector(64'h1111_2222_3333_4444, 0, 0);

    for (int n = 0; n < 6; n++) run_vector({$urandom, $urandom}, 2, 0);

    force dut.vec_count = 16'hFFFF;
    #1;
    release dut.vec_count;
    #1;
    chk("vec_count_preload", vec_count, 16'hFFFF);
    exp_vc = 16'hFFFF;
    run_vector({$urandom, $urandom}, 0, 1);
    chk("vec_count_wrap", vec_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
